// File: rtl/stoch_arith_core.sv
// -----------------------------------------------------------------------------
// stoch_arith_core
//
// Stochastic-computing arithmetic core. Two WIDTH-bit binary probabilities are
// turned into bitstreams by comparing them against free-running 31-bit LFSRs.
// The streams are combined bit-serially in one of four modes. The ones are
// counted over a 2^LEN_LOG2-cycle window to give a binary result.
//
// Ports
//   clk       in   1            single clock, all state on rising edge
//   rst_n     in   1            synchronous reset, ACTIVE-HIGH despite the name
//   start     in   1            run request, accepted only while idle
//   mode      in   2            00 AND, 01 XNOR, 10 MUX (scaled add), 11 OR
//   op_a      in   WIDTH        probability A
//   op_b      in   WIDTH        probability B
//   busy      out  1            high while a window is being counted
//   done      out  1            one-cycle pulse, result updated
//   result    out  LEN_LOG2+1   ones count 0..N, held until the next done
//   sn_out    out  1            registered combined stream bit (debug tap)
//   sn_valid  out  1            sn_out carries a bit of the running window
//
// Build option
//   STOCH_SN_TAP_EN  defined   -> sn_out / sn_valid carry the debug tap
//                    undefined -> sn_out / sn_valid tied low, tap regs removed
// -----------------------------------------------------------------------------
module stoch_arith_core #(
    parameter int          WIDTH    = 4,
    parameter int          LEN_LOG2 = 3,
    parameter logic [30:0] SEED_A   = 31'd1,
    parameter logic [30:0] SEED_B   = 31'd2,
    parameter logic [30:0] SEED_S   = 31'd4
) (
    input  logic                clk,
    input  logic                rst_n,
    input  logic                start,
    input  logic [1:0]          mode,
    input  logic [WIDTH-1:0]    op_a,
    input  logic [WIDTH-1:0]    op_b,
    output logic                busy,
    output logic                done,
    output logic [LEN_LOG2:0]   result,
    output logic                sn_out,
    output logic                sn_valid
);

    typedef enum logic {
        S_IDLE = 1'b0,
        S_RUN  = 1'b1
    } state_t;

    // x^31 + x^28 + 1 Fibonacci LFSR, shifting towards the MSB.
    function automatic logic [30:0] lfsr_step(input logic [30:0] s);
        return {s[29:0], s[27] ^ s[30]};
    endfunction

    function automatic logic sc_combine(input logic [1:0] m, input logic sa,
                                        input logic sb, input logic sel);
        logic c;
        case (m)
            2'b00:   c = sa & sb;
            2'b01:   c = ~(sa ^ sb);
            2'b10:   c = sel ? sb : sa;
            default: c = sa | sb;
        endcase
        return c;
    endfunction

    state_t                r_state;
    state_t                w_state_next;

    logic [30:0]           r_lfsr_a;
    logic [30:0]           r_lfsr_b;
    logic [30:0]           r_lfsr_s;

    logic [WIDTH-1:0]      r_a_q;
    logic [WIDTH-1:0]      r_b_q;
    logic [1:0]            r_mode_q;

    logic [LEN_LOG2:0]     r_count;
    logic [LEN_LOG2-1:0]   r_bit_cnt;
    logic                  r_done;
    logic [LEN_LOG2:0]     r_result;

    logic                  w_sa;
    logic                  w_sb;
    logic                  w_sel;
    logic                  w_c;
    logic                  w_last;
    logic                  w_accept;
    logic [LEN_LOG2:0]     w_count_inc;

    // Comparator uses the top WIDTH LFSR bits as the random threshold.
    assign w_sa        = r_lfsr_a[30:31-WIDTH] < r_a_q;
    assign w_sb        = r_lfsr_b[30:31-WIDTH] < r_b_q;
    assign w_sel       = r_lfsr_s[30];
    assign w_c         = sc_combine(r_mode_q, w_sa, w_sb, w_sel);
    // Bit counter is LEN_LOG2 wide, so all-ones marks the final bit N-1.
    assign w_last      = &r_bit_cnt;
    assign w_accept    = (r_state == S_IDLE) && start;
    assign w_count_inc = r_count + {{LEN_LOG2{1'b0}}, w_c};

    // ---------------- FSM: state register ----------------
    always_ff @(posedge clk) begin
        if (rst_n) begin
            r_state <= S_IDLE;
        end else begin
            r_state <= w_state_next;
        end
    end

    // ---------------- FSM: next-state logic ----------------
    always_comb begin
        w_state_next = r_state;
        case (r_state)
            S_IDLE:  if (start)  w_state_next = S_RUN;
            S_RUN:   if (w_last) w_state_next = S_IDLE;
            default:             w_state_next = S_IDLE;
        endcase
    end

    // ---------------- FSM: outputs ----------------
    always_comb begin
        busy = (r_state == S_RUN);
    end

    // ---------------- stream generators and counter ----------------
    always_ff @(posedge clk) begin
        if (rst_n) begin
            r_lfsr_a  <= SEED_A;
            r_lfsr_b  <= SEED_B;
            r_lfsr_s  <= SEED_S;
            r_count   <= '0;
            r_bit_cnt <= '0;
            r_done    <= 1'b0;
            r_result  <= '0;
        end else begin
            r_lfsr_a <= lfsr_step(r_lfsr_a);
            r_lfsr_b <= lfsr_step(r_lfsr_b);
            r_lfsr_s <= lfsr_step(r_lfsr_s);
            r_done   <= 1'b0;
            if (w_accept) begin
                r_count   <= '0;
                r_bit_cnt <= '0;
            end else if (r_state == S_RUN) begin
                r_count   <= w_count_inc;
                r_bit_cnt <= r_bit_cnt + 1'b1;
                if (w_last) begin
                    // Include the final bit directly; count alone tops out at N-1.
                    r_result <= w_count_inc;
                    r_done   <= 1'b1;
                end
            end
        end
    end

    // Operand/mode capture: only refreshed on an accepted start, so changes
    // while running have no effect.
    always_ff @(posedge clk) begin
        if (w_accept) begin
            r_a_q    <= op_a;
            r_b_q    <= op_b;
            r_mode_q <= mode;
        end
    end

    assign done   = r_done;
    assign result = r_result;

`ifdef STOCH_SN_TAP_EN
    logic r_sn_out;
    logic r_sn_valid;

    // ---------------- debug tap register ----------------
    always_ff @(posedge clk) begin
        if (rst_n) begin
            r_sn_out   <= 1'b0;
            r_sn_valid <= 1'b0;
        end else begin
            r_sn_out   <= w_c;
            r_sn_valid <= (r_state == S_RUN);
        end
    end

    assign sn_out   = r_sn_out;
    assign sn_valid = r_sn_valid;
`else
    assign sn_out   = 1'b0;
    assign sn_valid = 1'b0;
`endif

endmodule

// File: doc/stoch_arith_core.md
# stoch_arith_core

Parametrised stochastic-computing arithmetic core: converts two WIDTH-bit binary probabilities into stochastic bitstreams with free-running LFSRs, combines them bit-serially in one of four selectable modes, and counts ones over a 2^LEN_LOG2-cycle window back into binary. It is the start/done-handshaked successor of the fixed 4-bit, 8-cycle bipolar multiplier, and sits between the ui_in operand pins and uo_out in the top-level wrapper.

## Interface
Parameters:
- WIDTH, 4, operand width in bits (legal 2..16); comparator uses LFSR bits [30:31-WIDTH]
- LEN_LOG2, 3, log2 of stream length N (legal 1..12)
- SEED_A, 31'd1, reset value of operand-A LFSR (nonzero)
- SEED_B, 31'd2, reset value of operand-B LFSR (nonzero)
- SEED_S, 31'd4, reset value of select LFSR used by scaled-add mode (nonzero)

Ports:
- clk  in  1  single clock, all state on rising edge
- rst_n  in  1  synchronous, active-high reset (asserted = 1, sampled on clk)
- start  in  1  request; accepted only in IDLE
- mode  in  2  00 unipolar multiply (AND), 01 bipolar multiply (XNOR), 10 scaled add (MUX), 11 saturating add (OR)
- op_a  in  WIDTH  probability A
- op_b  in  WIDTH  probability B
- busy  out  1  high in RUN
- done  out  1  one-cycle pulse, result valid
- result  out  LEN_LOG2+1  ones count over the window, 0..N, held until next done
- sn_out  out  1  registered combined stream bit (debug tap)
- sn_valid  out  1  sn_out carries a RUN bit

## Operation
- Three 31-bit Fibonacci LFSRs, polynomial x^31+x^28+1 (bit0 <= b27^b30, shift left), advance every cycle in all states except reset.
- SN bits (combinational): sa = lfsr_a[30:31-WIDTH] < a_q; sb likewise with b_q; sel = lfsr_s[30].
- Combined bit c: AND(sa,sb); XNOR(sa,sb); sel ? sb : sa; OR(sa,sb) per mode_q.
- FSM states:
  - IDLE: busy=0. On start=1: latch op_a, op_b, mode into a_q, b_q, mode_q; clear count and bit counter; go RUN.
  - RUN: busy=1. Each cycle count <= count + c, bit counter increments. On bit counter = N-1: result <= count + c, done <= 1, go IDLE.
- No DONE state; back-to-back start accepted on the cycle done is high.
- Operands/mode changes during RUN ignored (latched copies used). start during RUN ignored.
- Count width LEN_LOG2+1; all-ones stream gives result = N exactly, no overflow flag, no wrap.
- Operand value 0 yields sa=0 always; value 2^WIDTH-1 yields sa=1 except when LFSR top bits all ones.

## Timing
- Reset (rst_n=1 at edge): state IDLE, busy=0, done=0, result=0, sn_out=0, sn_valid=0, count=0, LFSRs = seeds. Reset overrides start and aborts RUN with no done.
- start sampled at edge E0 -> busy high after E0; bits sampled at edges E1..EN; done and new result visible after EN, for exactly one cycle; busy low from same cycle. Latency start-to-done = N+1 edges.
- sn_out/sn_valid: register c and (state==RUN) each edge; sn_valid high for exactly N cycles, lagging busy by one cycle.
- result changes only on the done edge.

## Configuration
- STOCH_SN_TAP_EN: defined -> sn_out and sn_valid driven as above. Undefined -> both tied to 0, tap registers removed; all other behaviour identical.

## Test plan
- Reset then idle 5 cycles -> busy=0, done=0, result=0, sn_valid=0 throughout.
- WIDTH=4, LEN_LOG2=3, mode=00, op_a=0, op_b=15, start 1 cycle -> busy for 8 cycles, done at edge 9 after start, result=0.
- mode=01, op_a=0, op_b=0 -> every c=1, result=8 (4'b1000), sn_valid high 8 cycles with sn_out=1.
- mode=10 and 11, op_a=0, op_b=0 -> result=0; mode=11 op_a=op_b=15 over 32 seeded runs -> mean result within 7.0..8.0, compared against bit-exact LFSR reference model.
- start re-pulsed and op_a changed mid-RUN -> ignored, result matches latched operands; start on done cycle -> new RUN begins next cycle.
- rst_n=1 at RUN cycle 4 -> no done, busy=0 next cycle, result=0, LFSRs reseeded; subsequent run equals first-run-after-reset result.
